// File: rtl/axim_rd_arb_pkg.sv
// Shared types and the round-robin pick helper for the AXI-master read arbiter.
// Also intended for reuse by the write-side arbiter.
package axim_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER
  } state_t;

  localparam int MAX_REQ = 32;
  localparam int MAX_IW  = 5;

  // One-hot pick of the first set bit at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int                 ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] pick;
    int                 idx;
    pick = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_IW-1:0]]) begin
          pick = '0;
          pick[idx[MAX_IW-1:0]] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester pick plus rotating priority pointer.
// RD_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, no pointer.
module rr_arbiter
  import axim_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IW-1:0]      last_idx,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      pick_idx
);

  logic [MAX_REQ-1:0] pick_w;

`ifdef RD_ARB_FIXED_PRIO_EN
  assign pick_w = rr_pick(MAX_REQ'(req), 0, NUM_REQ);

  logic unused;
  assign unused = ^{clk, reset, advance, last_idx};
`else
  logic [IW-1:0] ptr;

  // Priority rotates to the port after the one that just finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);
    end
  end

  assign pick_w = rr_pick(MAX_REQ'(req), int'(ptr), NUM_REQ);
`endif

  assign pick = pick_w[NUM_REQ-1:0];

  logic unused_hi;
  assign unused_hi = ^pick_w;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

endmodule

// File: rtl/axim_rd_arbiter.sv
// Arbitrates NUM_REQ read requesters onto one AXI-master read channel.
// Build option RD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module axim_rd_arbiter
  import axim_rd_arb_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_raddr_i,
  input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_size_i,
  output logic [NUM_REQ-1:0]                      req_ack_o,
  output logic [NUM_REQ-1:0]                      req_done_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           req_tdata_o,
  output logic [NUM_REQ-1:0]                      req_tvalid_o,
  output logic                                    req_tlast_o,
  input  logic [NUM_REQ-1:0]                      req_tready_i,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           ctrl_raddr_offset_o,
  output logic [C_XFER_SIZE_WIDTH-1:0]            ctrl_rxfer_size_o,
  output logic                                    ctrl_rstart_o,
  input  logic                                    ctrl_rdone_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           rd_tdata_i,
  input  logic                                    rd_tvalid_i,
  output logic                                    rd_tready_o,
  input  logic                                    rd_tlast_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;

  state_t state, state_n;

  logic               take;
  logic               start_n;
  logic               finish;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] done_q;
  logic [AW-1:0]      addr_q;
  logic [XW-1:0]      size_q;
  logic               rstart_q;
  logic               xfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid_i),
    .advance  (finish),
    .last_idx (gidx),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Zero-size requests pass through ISSUE without a start pulse.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    start_n = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid_i) begin
          take    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (size_q == '0) begin
          finish  = 1'b1;
          state_n = IDLE;
        end else begin
          start_n = 1'b1;
          state_n = XFER;
        end
      end
      XFER: begin
        if (ctrl_rdone_i) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      rstart_q <= 1'b0;
    end else begin
      state    <= state_n;
      ack_q    <= take ? pick : '0;
      done_q   <= finish ? grant : '0;
      rstart_q <= start_n;
      if (take) begin
        grant  <= pick;
        gidx   <= pick_idx;
        addr_q <= req_raddr_i[pick_idx*AW +: AW];
        size_q <= req_size_i[pick_idx*XW +: XW];
      end
    end
  end

  assign xfer = (state == XFER);

  assign req_ack_o           = ack_q;
  assign req_done_o          = done_q;
  assign ctrl_rstart_o       = rstart_q;
  assign ctrl_raddr_offset_o = addr_q;
  assign ctrl_rxfer_size_o   = size_q;

  assign rd_tready_o  = xfer & req_tready_i[gidx];
  assign req_tvalid_o = (xfer & rd_tvalid_i) ? grant : '0;
  assign req_tdata_o  = xfer ? rd_tdata_i : '0;
  assign req_tlast_o  = xfer & rd_tlast_i;

endmodule
